// File: rtl/register_file_mp.sv
// register_file_mp: multi-port register file with write bypass, hardwired zero register and busy scoreboard.
module register_file_mp #(
  parameter int XLEN = 32,
  parameter int NREGS = 32,
  parameter int NRD = 2,
  parameter int NWR = 2,
  parameter bit ZERO_REG = 1,
  parameter bit BYPASS = 1,
  localparam int AW = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                issue_en,
  input  logic [AW-1:0]       issue_addr,
  output logic [NREGS-1:0]    busy_vec
);
  logic [XLEN-1:0] mem [NREGS];
  logic [XLEN-1:0] val [NREGS];
  logic [NREGS-1:0] hit, busy, busy_nxt;
  // val is each register's next value; later write ports override earlier ones
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      hit[r] = 1'b0;
      val[r] = mem[r];
      for (int k = 0; k < NWR; k++)
        if (wr_en[k] && wr_addr[k*AW +: AW] == AW'(r)) begin
          hit[r] = 1'b1;
          val[r] = wr_data[k*XLEN +: XLEN];
        end
      if (ZERO_REG && r == 0) val[r] = '0;
      busy_nxt[r] = (ZERO_REG && r == 0) ? 1'b0 :
                    (issue_en && issue_addr == AW'(r)) || (busy[r] && !hit[r]);
    end
  end
  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] a;
    logic ok;
    assign a = rd_addr[i*AW +: AW];
    assign ok = int'(a) < NREGS;
    assign rd_data[i*XLEN +: XLEN] = ok ? (BYPASS ? val[a] : mem[a]) : '0;
    assign rd_busy[i] = ok && busy[a] && !(BYPASS && hit[a]);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      busy <= '0;
      for (int r = 0; r < NREGS; r++) mem[r] <= '0;
    end else begin
      busy <= busy_nxt;
      for (int r = 0; r < NREGS; r++) mem[r] <= val[r];
    end
  assign busy_vec = busy;
endmodule

// File: tb/tb_register_file_mp.sv
// tb_register_file_mp: randomized and directed checks of register_file_mp against an array-based model.
module tb_register_file_mp;
  logic clk = 0, rst = 0;
  logic [9:0] rd_addr;
  logic [63:0] rd_data;
  logic [1:0] rd_busy;
  logic [1:0] wr_en;
  logic [9:0] wr_addr;
  logic [63:0] wr_data;
  logic issue_en;
  logic [4:0] issue_addr;
  logic [31:0] busy_vec;
  logic [4:0] ra [2];
  logic [4:0] wa [2];
  logic [31:0] wd [2];
  logic [31:0] regs_m [32];
  bit busy_m [32];
  int n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  assign rd_addr = {ra[1], ra[0]};
  assign wr_addr = {wa[1], wa[0]};
  assign wr_data = {wd[1], wd[0]};
  register_file_mp dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .issue_en(issue_en), .issue_addr(issue_addr), .busy_vec(busy_vec)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic bit written(input int a);
    for (int k = 0; k < 2; k++) if (wr_en[k] && wa[k] == a) return 1;
    return 0;
  endfunction
  function automatic logic [31:0] exp_rd(input int a);
    logic [31:0] v = regs_m[a];
    for (int k = 0; k < 2; k++) if (wr_en[k] && wa[k] == a) v = wd[k];
    return a == 0 ? 32'h0 : v;
  endfunction
  function automatic logic [31:0] exp_vec();
    logic [31:0] v = '0;
    for (int r = 0; r < 32; r++) v[r] = busy_m[r];
    return v;
  endfunction
  task automatic model_reset();
    for (int r = 0; r < 32; r++) begin regs_m[r] = 0; busy_m[r] = 0; end
  endtask
  task automatic model_step();
    for (int k = 0; k < 2; k++)
      if (wr_en[k]) begin
        if (wa[k] != 0) regs_m[wa[k]] = wd[k];
        busy_m[wa[k]] = 0;
      end
    if (issue_en && issue_addr != 0) busy_m[issue_addr] = 1;
  endtask
  task automatic idle();
    wr_en = 0; issue_en = 0; issue_addr = 0;
    for (int k = 0; k < 2; k++) begin wa[k] = 0; wd[k] = 0; ra[k] = 0; end
  endtask
  task automatic cycle();
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rd_data%0d@%0d", i, ra[i]), rd_data[i*32 +: 32], exp_rd(ra[i]));
      chk($sformatf("rd_busy%0d@%0d", i, ra[i]), 32'(rd_busy[i]),
          32'(ra[i] != 0 && busy_m[ra[i]] && !written(ra[i])));
    end
    chk("busy_vec", busy_vec, exp_vec());
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask
  initial begin
    idle();
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("reset_busy_vec", busy_vec, 32'h0);
    chk("reset_rd_data", rd_data[31:0], 32'h0);
    rst = 1;
    @(negedge clk);
    wr_en = 2'b01; wa[0] = 5; wd[0] = 32'hDEADBEEF; ra[0] = 5;
    #1 chk("t2_bypass", rd_data[31:0], 32'hDEADBEEF);
    cycle();
    idle(); ra[1] = 5;
    #1 chk("t2_stored", rd_data[63:32], 32'hDEADBEEF);
    cycle();
    wr_en = 2'b11; wa[0] = 7; wd[0] = 32'h1111; wa[1] = 7; wd[1] = 32'h2222;
    cycle();
    idle(); ra[0] = 7;
    #1 chk("t3_conflict", rd_data[31:0], 32'h2222);
    cycle();
    wr_en = 2'b01; wa[0] = 0; wd[0] = 32'hFFFFFFFF; issue_en = 1; issue_addr = 0; ra[0] = 0;
    #1 chk("t4_zero_bypass", rd_data[31:0], 32'h0);
    cycle();
    idle();
    #1 chk("t4_zero_busy", 32'(busy_vec[0]), 32'h0);
    chk("t4_zero_stored", rd_data[31:0], 32'h0);
    cycle();
    issue_en = 1; issue_addr = 9; ra[0] = 9;
    #1 chk("t5_issue_no_raise", 32'(rd_busy[0]), 32'h0);
    cycle();
    idle(); ra[0] = 9;
    #1 chk("t5_busy_vec", 32'(busy_vec[9]), 32'h1);
    chk("t5_rd_busy", 32'(rd_busy[0]), 32'h1);
    cycle();
    wr_en = 2'b10; wa[1] = 9; wd[1] = 32'h42; ra[0] = 9;
    #1 chk("t5_wb_rd_busy", 32'(rd_busy[0]), 32'h0);
    chk("t5_wb_rd_data", rd_data[31:0], 32'h42);
    cycle();
    idle();
    #1 chk("t5_cleared", 32'(busy_vec[9]), 32'h0);
    cycle();
    issue_en = 1; issue_addr = 9; wr_en = 2'b01; wa[0] = 9; wd[0] = 32'h99;
    cycle();
    idle(); ra[1] = 9;
    #1 chk("t6_set_wins", 32'(busy_vec[9]), 32'h1);
    chk("t6_data", rd_data[63:32], 32'h99);
    cycle();
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < 2; k++) begin
        wa[k] = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
        wd[k] = $urandom;
        ra[k] = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      end
      wr_en = 2'($urandom_range(0, 3));
      issue_en = 1'($urandom_range(0, 1));
      issue_addr = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      cycle();
      if (n == 200) begin
        idle();
        issue_en = 1; issue_addr = 3;
        cycle();
        idle(); ra[0] = 7; ra[1] = 3;
        rst = 0;
        #1 chk("midreset_busy_vec", busy_vec, 32'h0);
        chk("midreset_rd0", rd_data[31:0], 32'h0);
        chk("midreset_rd1", rd_data[63:32], 32'h0);
        chk("midreset_rd_busy", 32'(rd_busy), 32'h0);
        model_reset();
        @(negedge clk);
        rst = 1;
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
